i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares one downstream I2C slave bus between two upstream masters (M0, M1), each
//  reached through its own i2c_bypass channel. Watches both masters' filtered SCL/SDA,
//  detects START/STOP and grants one bypass channel at a time via bypass_en*.
//  Holds the non-owner's SCL low (clock stretch) so it sees a busy bus.
//  Recovers from a stalled owner by timeout. Sits between the pin-level bypass channels
//  and the board I2C pins.
// PARAMETERS
//  FILT_LEN       4        cycles a line must be stable before its filtered value changes
//  BUF_CYCLES     130      bus-free hold after release (tBUF, 1.3us @100MHz)
//  TIMEOUT_CYCLES 2500000  owner SCL inactivity limit (25ms @100MHz)
//  CNT_W          22       width of the timeout/buf counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  m0_scl_i       in   1  raw SCL sampled at M0 side (async)
//  m0_sda_i       in   1  raw SDA sampled at M0 side (async)
//  m1_scl_i       in   1  raw SCL sampled at M1 side (async)
//  m1_sda_i       in   1  raw SDA sampled at M1 side (async)
//  bypass_en0     out  1  1 = M0 bypass channel connected to downstream bus
//  bypass_en1     out  1  1 = M1 bypass channel connected to downstream bus
//  m0_scl_hold    out  1  1 = drive M0 SCL low (open-drain OE); 0 = release
//  m1_scl_hold    out  1  1 = drive M1 SCL low (open-drain OE); 0 = release
//  busy           out  1  1 whenever state != IDLE
//  owner          out  1  index of last/current owner (0 = M0)
//  timeout_pulse  out  1  1-cycle pulse on owner timeout
//  collision_pulse out 1  1-cycle pulse when both STARTs detected in the same cycle
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, owner=1 (so M0 wins first tie), counters 0.
//    Reset mid-transaction drops the grant immediately (async); no STOP is generated.
//  - Per line: 2-flop sync, then filter; filtered value changes only after FILT_LEN
//    consecutive equal synced samples. Filtered lines reset to 1.
//  - START(x): filtered SDA 1->0 while filtered SCL=1. STOP(x): SDA 0->1 while SCL=1.
//  - IDLE: holds=0, en=0. START on one master -> GRANTx. START on both in same cycle
//    -> grant the master != owner (round-robin), collision_pulse=1. Other events ignored.
//  - GRANTx: bypass_enx=1, other master's scl_hold=1, owner=x. Counter cleared on any
//    filtered SCL edge of Mx, else +1. STOP(x) -> RELEASE. Counter==TIMEOUT_CYCLES-1
//    -> RELEASE with timeout_pulse. STOP has priority over timeout in the same cycle.
//    Enabling the channel while Mx SDA=0/SCL=1 reproduces START downstream.
//  - RELEASE: en0=en1=0, both scl_hold=1, counter counts BUF_CYCLES then -> IDLE.
//    START events in RELEASE are ignored (SCL held, masters cannot issue them).
//  - Latency: raw START edge -> bypass_en 1: 2 sync + FILT_LEN + 1 registered cycles.
//    FILT_LEN+3 cycles must be < tHD;STA of slowest supported master.
//  - All outputs registered; en0 and en1 never 1 together, and never 1 while holding the
//    same master's SCL (assertion).
//  - Non-owner's SDA activity during GRANT is ignored (its SCL is held low).
// STRUCTURE
//  - Package i2c_arb_pkg: state encoding (ST_IDLE, ST_GRANT0, ST_GRANT1, ST_RELEASE),
//    owner codes OWN_M0/OWN_M1.
//  - Sub-module i2c_line_filter (sync + stable-count filter + rise/fall strobes),
//    instantiated 4x; START/STOP decode and FSM in the top.
// TESTING  (FILT_LEN=4, BUF_CYCLES=10, TIMEOUT_CYCLES=100)
//  - Reset, lines high -> all outputs 0, owner=1, busy=0.
//  - M0 START then 3 bytes then STOP -> bypass_en0=1 within 7 clks of SDA fall,
//    m1_scl_hold=1 throughout; after STOP en0=0, both holds 1 for 10 clks, then 0.
//  - M1 START while M0 owns -> ignored; en1 stays 0; M1 SCL held; M1 START after
//    release -> en1=1, owner=1.
//  - Same-cycle START on M0/M1 after reset -> GRANT0, collision_pulse=1 once; repeat
//    after release -> GRANT1.
//  - M0 START, then SCL frozen 100 clks -> timeout_pulse=1, RELEASE, IDLE after 10 clks.
//  - 3-clk SDA glitch while SCL high in IDLE -> no grant; reset asserted in GRANT0
//    -> en0=0 and m1_scl_hold=0 immediately.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: arbiter state encoding and owner codes
package i2c_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1, ST_RELEASE} state_t;
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop sync, stable-count glitch filter and registered edge strobes
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  // flip on the FILT_LEN-th consecutive differing synced sample
  assign flip = (sync[1] != filt) && (cnt == CW'(FILT_LEN - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= 2'b11;
      cnt <= '0;
      filt <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] != filt && !flip) ? cnt + 1'b1 : '0;
      filt <= flip ? sync[1] : filt;
      rise <= flip & sync[1];
      fall <= flip & ~sync[1];
    end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: grants one of two I2C masters the downstream bus, stretching the other
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int FILT_LEN       = 4,
  parameter int BUF_CYCLES     = 130,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int CNT_W          = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_scl_i,
  input  logic m0_sda_i,
  input  logic m1_scl_i,
  input  logic m1_sda_i,
  output logic bypass_en0,
  output logic bypass_en1,
  output logic m0_scl_hold,
  output logic m1_scl_hold,
  output logic busy,
  output logic owner,
  output logic timeout_pulse,
  output logic collision_pulse
);
  logic [3:0] raw, filt, rise, fall;
  logic [1:0] start, stop, scl_edge;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic owner_nxt, tmo_nxt, col_nxt, g, x;
  assign raw = {m1_sda_i, m1_scl_i, m0_sda_i, m0_scl_i};
  for (genvar i = 0; i < 4; i++) begin : g_filt
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk(clk), .reset(reset), .raw(raw[i]),
      .filt(filt[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  assign start = {fall[3] & filt[2], fall[1] & filt[0]};
  assign stop = {rise[3] & filt[2], rise[1] & filt[0]};
  assign scl_edge = {rise[2] | fall[2], rise[0] | fall[0]};
  assign g = (&start) ? ~owner : start[1];
  assign x = (state == ST_GRANT1);
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + 1'b1;
    owner_nxt = owner;
    tmo_nxt = 1'b0;
    col_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (|start) begin
          state_nxt = g ? ST_GRANT1 : ST_GRANT0;
          owner_nxt = g ? OWN_M1 : OWN_M0;
          col_nxt = &start;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        cnt_nxt = scl_edge[x] ? '0 : cnt + 1'b1;
        if (stop[x]) begin
          state_nxt = ST_RELEASE;
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ST_RELEASE;
          cnt_nxt = '0;
          tmo_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt == CNT_W'(BUF_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      owner <= OWN_M1;
      bypass_en0 <= 1'b0;
      bypass_en1 <= 1'b0;
      m0_scl_hold <= 1'b0;
      m1_scl_hold <= 1'b0;
      busy <= 1'b0;
      timeout_pulse <= 1'b0;
      collision_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      owner <= owner_nxt;
      bypass_en0 <= state_nxt == ST_GRANT0;
      bypass_en1 <= state_nxt == ST_GRANT1;
      m0_scl_hold <= state_nxt == ST_GRANT1 || state_nxt == ST_RELEASE;
      m1_scl_hold <= state_nxt == ST_GRANT0 || state_nxt == ST_RELEASE;
      busy <= state_nxt != ST_IDLE;
      timeout_pulse <= tmo_nxt;
      collision_pulse <= col_nxt;
    end
  a_grant_safe: assert property (@(posedge clk) disable iff (reset)
    !(bypass_en0 && bypass_en1) && !(bypass_en0 && m0_scl_hold) && !(bypass_en1 && m1_scl_hold));
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: scoreboard of expected output-vector changes plus latency/timing checks
module tb_i2c_bus_arbiter;
  localparam int H = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] scl = 2'b11;
  logic [1:0] sda = 2'b11;
  logic en0, en1, h0, h1, busy, owner, tmo, col;
  logic [7:0] vec, prev;
  logic [7:0] exp_q[$];
  int n_total = 0;
  int n_bad = 0;
  int n;
  bit mon_on = 0;
  assign vec = {en0, en1, h0, h1, busy, owner, tmo, col};
  always #5 clk = ~clk;
  i2c_bus_arbiter #(.FILT_LEN(4), .BUF_CYCLES(10), .TIMEOUT_CYCLES(100), .CNT_W(22)) dut (
    .clk(clk), .reset(reset),
    .m0_scl_i(scl[0]), .m0_sda_i(sda[0]), .m1_scl_i(scl[1]), .m1_sda_i(sda[1]),
    .bypass_en0(en0), .bypass_en1(en1), .m0_scl_hold(h0), .m1_scl_hold(h1),
    .busy(busy), .owner(owner), .timeout_pulse(tmo), .collision_pulse(col)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_vec(input logic [7:0] mask, input logic [7:0] val, input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if ((vec & mask) == val) begin
        cyc = i;
        return;
      end
    end
  endtask
  task automatic start(input int m);
    sda[m] = 1'b0;
    wait_vec(m ? 8'h40 : 8'h80, m ? 8'h40 : 8'h80, 20, n);
    check("start_lat", n, 7);
    scl[m] = 1'b0;
    idle(H);
  endtask
  task automatic send_bit(input int m, input logic b);
    sda[m] = b;
    idle(H);
    scl[m] = 1'b1;
    idle(H);
    scl[m] = 1'b0;
    idle(H);
  endtask
  task automatic stop_seq(input int m);
    sda[m] = 1'b0;
    idle(H);
    scl[m] = 1'b1;
    idle(H);
    sda[m] = 1'b1;
    wait_vec(8'h30, 8'h30, 20, n);
    check("stop_lat", n, 7);
    check("rel_en", vec[7:6], 0);
    wait_vec(8'h30, 8'h00, 30, n);
    check("buf_len", n, 10);
  endtask
  always @(negedge clk)
    if (mon_on && vec !== prev) begin
      if (exp_q.size() == 0) check("sb_extra", vec, prev);
      else check("sb", vec, exp_q.pop_front());
      prev = vec;
    end
  initial begin
    #200us;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    idle(3);
    check("rst_vec", vec, 8'h04);
    reset = 1'b0;
    idle(10);
    check("idle_vec", vec, 8'h04);
    prev = vec;
    mon_on = 1;
    // M0 transaction, M1 tries to start while M0 owns the bus
    exp_q.push_back(8'h98);
    start(0);
    sda[1] = 1'b0;
    idle(H);
    check("m1_ignored_en1", vec[6], 0);
    check("m1_held", vec[4], 1);
    sda[1] = 1'b1;
    idle(H);
    for (int i = 0; i < 27; i++) send_bit(0, 1'($urandom_range(0, 1)));
    check("m1_held_end", vec[4], 1);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h00);
    stop_seq(0);
    // M1 after release
    exp_q.push_back(8'h6C);
    start(1);
    check("owner_m1", vec[2], 1);
    for (int i = 0; i < 9; i++) send_bit(1, 1'($urandom_range(0, 1)));
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h04);
    stop_seq(1);
    // same-cycle STARTs after reset, then again after release
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h98);
    sda = 2'b00;
    wait_vec(8'h80, 8'h80, 20, n);
    check("col0_lat", n, 7);
    check("col0_pulse", vec[0], 1);
    sda[1] = 1'b1;
    scl[0] = 1'b0;
    idle(H);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h00);
    stop_seq(0);
    exp_q.push_back(8'h6D);
    exp_q.push_back(8'h6C);
    sda = 2'b00;
    wait_vec(8'h40, 8'h40, 20, n);
    check("col1_lat", n, 7);
    check("col1_pulse", vec[0], 1);
    sda[0] = 1'b1;
    scl[1] = 1'b0;
    idle(H);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h04);
    stop_seq(1);
    // owner timeout with SCL frozen high
    exp_q.push_back(8'h98);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h00);
    sda[0] = 1'b0;
    wait_vec(8'h80, 8'h80, 20, n);
    check("to_start_lat", n, 7);
    wait_vec(8'h02, 8'h02, 150, n);
    check("to_cycles", n, 100);
    check("to_holds", vec[5:4], 2'b11);
    wait_vec(8'h30, 8'h00, 30, n);
    check("to_buf", n, 10);
    sda[0] = 1'b1;
    idle(H);
    // 3-clock SDA glitch in IDLE
    sda[0] = 1'b0;
    idle(3);
    sda[0] = 1'b1;
    idle(20);
    check("glitch_busy", vec[3], 0);
    check("glitch_en0", vec[7], 0);
    // reset while M0 owns the bus
    exp_q.push_back(8'h98);
    start(0);
    exp_q.push_back(8'h04);
    reset = 1'b1;
    scl[0] = 1'b1;
    sda[0] = 1'b1;
    #1;
    check("rst_en0", en0, 0);
    check("rst_h1", h1, 0);
    check("rst_busy", busy, 0);
    idle(3);
    reset = 1'b0;
    idle(20);
    check("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
